// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan controller:
//   - state_e      : scan FSM states (IDLE / BLANK / SHOW)
//   - SEG_TABLE    : hex digit 0..F to segment pattern, bit0=a .. bit6=g,
//                    active-high
//   - hex_to_seg() : table lookup helper
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    // Entry 15 is listed first so that SEG_TABLE[n] is the pattern for hex n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex nibble to 7-segment decoder.
// Ports:
//   hex : in  4-bit hex value
//   seg : out 7-bit segment pattern, bit0=a .. bit6=g, active-high
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern
    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for a NUM_DIGITS-digit 7-segment display.
// One digit is driven at a time over a shared segment bus. Each digit slot is
// SCAN_DIV cycles long: BLANK_CYC dark cycles (anti-ghosting) followed by the
// lit part. New display values arrive via a valid/ready handshake into a
// shadow register and are copied to the display register only at a frame
// boundary (or immediately while idle), so a frame never shows mixed values.
//
// Optional feature (compile-time macro SEG7_LZB_EN):
//   leading-zero blanking. A digit whose nibble and all higher nibbles are
//   zero stays dark in its slot; digit 0 is always shown. Slot timing is
//   unchanged. Without the macro every digit is shown.
//
// Ports:
//   clk        : in  system clock
//   clr        : in  synchronous active-high reset
//   enable     : in  1 = scan running, 0 = display dark / idle
//   load_valid : in  load_data valid
//   load_ready : out controller can accept a new value (registered)
//   load_data  : in  hex nibbles, nibble i = digit i (digit 0 = rightmost)
//   digit_en   : out one-hot active-high digit select (registered)
//   seg_out    : out segments bit0=a .. bit6=g, active-high (registered)
//   frame_done : out one-cycle pulse on the last cycle of a frame (registered)
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 8
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg_out,
    output logic                    frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DATA_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    // Scan state
    state_e              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [IDX_W-1:0]    idx_r;
    state_e              next_state_s;
    logic [CNT_W-1:0]    next_cnt_s;
    logic [IDX_W-1:0]    next_idx_s;

    // Display / handshake state
    logic [DATA_W-1:0]   disp_r;
    logic [DATA_W-1:0]   shadow_r;
    logic                pending_r;
    logic [DATA_W-1:0]   next_disp_s;
    logic [DATA_W-1:0]   next_shadow_s;
    logic                next_pending_s;
    logic                boundary_s;
    logic                accept_s;

    // Output registers and their next values
    logic [NUM_DIGITS-1:0] digit_en_r;
    logic [6:0]            seg_out_r;
    logic                  frame_done_r;
    logic                  load_ready_r;
    logic [NUM_DIGITS-1:0] next_digit_en_s;
    logic [6:0]            next_seg_s;
    logic                  next_frame_done_s;

    logic [3:0]            nibble_s;
    logic [6:0]            dec_seg_s;

`ifdef SEG7_LZB_EN
    logic [NUM_DIGITS-1:0] lead_blank_s;
`endif

    assign digit_en   = digit_en_r;
    assign seg_out    = seg_out_r;
    assign frame_done = frame_done_r;
    assign load_ready = load_ready_r;

    // Last cycle of the last digit slot: the frame boundary
    assign boundary_s = (state_r == SHOW) && (cnt_r == SCAN_LAST) && (idx_r == IDX_LAST);
    assign accept_s   = load_valid & load_ready_r;

    // State register: FSM, slot counter, digit index and display data
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            disp_r    <= {DATA_W{1'b0}};
            shadow_r  <= {DATA_W{1'b0}};
            pending_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= next_cnt_s;
            idx_r     <= next_idx_s;
            disp_r    <= next_disp_s;
            shadow_r  <= next_shadow_s;
            pending_r <= next_pending_s;
        end
    end

    // Next-state logic for the scan FSM, slot counter and digit index
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        next_idx_s   = idx_r;
        if (!enable) begin
            // Dropping enable abandons the frame; restart is from digit 0
            next_state_s = IDLE;
            next_cnt_s   = {CNT_W{1'b0}};
            next_idx_s   = {IDX_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    next_cnt_s = {CNT_W{1'b0}};
                    next_idx_s = {IDX_W{1'b0}};
                    if (BLANK_CYC == 0) begin
                        next_state_s = SHOW;
                    end else begin
                        next_state_s = BLANK;
                    end
                end
                BLANK: begin
                    next_cnt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == BLANK_LAST) begin
                        next_state_s = SHOW;
                    end else begin
                        next_state_s = BLANK;
                    end
                end
                SHOW: begin
                    if (cnt_r == SCAN_LAST) begin
                        next_cnt_s = {CNT_W{1'b0}};
                        if (idx_r == IDX_LAST) begin
                            next_idx_s = {IDX_W{1'b0}};
                        end else begin
                            next_idx_s = idx_r + IDX_W'(1);
                        end
                        if (BLANK_CYC == 0) begin
                            next_state_s = SHOW;
                        end else begin
                            next_state_s = BLANK;
                        end
                    end else begin
                        next_cnt_s   = cnt_r + CNT_W'(1);
                        next_state_s = SHOW;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    next_cnt_s   = {CNT_W{1'b0}};
                    next_idx_s   = {IDX_W{1'b0}};
                end
            endcase
        end
    end

    // Handshake and tear-free apply of the shadow value
    always_comb begin
        next_disp_s    = disp_r;
        next_shadow_s  = shadow_r;
        next_pending_s = pending_r;
        // accept_s implies pending_r == 0, so accept and apply never coincide;
        // a value accepted on a boundary waits for the following boundary.
        if (accept_s) begin
            next_shadow_s  = load_data;
            next_pending_s = 1'b1;
        end else if (pending_r && ((state_r == IDLE) || boundary_s)) begin
            next_disp_s    = shadow_r;
            next_pending_s = 1'b0;
        end else begin
            next_pending_s = pending_r;
        end
    end

    // Select the nibble of the digit that will be scanned next cycle
    always_comb begin
        nibble_s = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (next_idx_s == IDX_W'(i)) begin
                nibble_s = next_disp_s[i*4 +: 4];
            end else begin
                nibble_s = nibble_s;
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .hex (nibble_s),
        .seg (dec_seg_s)
    );

`ifdef SEG7_LZB_EN
    // Mark digits whose nibble and every higher nibble are zero (digit 0 exempt)
    always_comb begin
        logic above_zero_v;
        above_zero_v = 1'b1;
        lead_blank_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            above_zero_v = above_zero_v & (next_disp_s[i*4 +: 4] == 4'h0);
            if (i != 0) begin
                lead_blank_s[i] = above_zero_v;
            end else begin
                lead_blank_s[i] = 1'b0;
            end
        end
    end
`endif

    // Output decode from next-cycle state so the registered outputs line up with it
    always_comb begin
        next_digit_en_s = {NUM_DIGITS{1'b0}};
        next_seg_s      = 7'h00;
        if (next_state_s == SHOW) begin
`ifdef SEG7_LZB_EN
            if (lead_blank_s[next_idx_s]) begin
                next_digit_en_s = {NUM_DIGITS{1'b0}};
                next_seg_s      = 7'h00;
            end else begin
                next_digit_en_s = DIGIT_ONE << next_idx_s;
                next_seg_s      = dec_seg_s;
            end
`else
            next_digit_en_s = DIGIT_ONE << next_idx_s;
            next_seg_s      = dec_seg_s;
`endif
        end else begin
            next_digit_en_s = {NUM_DIGITS{1'b0}};
            next_seg_s      = 7'h00;
        end
        next_frame_done_s = (next_state_s == SHOW) && (next_cnt_s == SCAN_LAST) &&
                            (next_idx_s == IDX_LAST);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (clr) begin
            digit_en_r   <= {NUM_DIGITS{1'b0}};
            seg_out_r    <= 7'h00;
            frame_done_r <= 1'b0;
            load_ready_r <= 1'b1;
        end else begin
            digit_en_r   <= next_digit_en_s;
            seg_out_r    <= next_seg_s;
            frame_done_r <= next_frame_done_s;
            load_ready_r <= ~next_pending_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  digit_en;
    logic [6:0]  seg_out;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg7_scan_ctrl #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .BLANK_CYC  (1)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .digit_en   (digit_en),
        .seg_out    (seg_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_en(input int d, input int c);
        logic [3:0] one;
        one = 4'b0001;
        if (c == 0) return 4'b0000;
        else return one << d;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input int c);
        logic [3:0] n;
        n = v[d*4 +: 4];
        if (c == 0) return 7'h00;
        else return seg_ref[n];
    endfunction

    task automatic test_reset;
        clr = 1'b1; enable = 1'b1; load_valid = 1'b1; load_data = 16'hFFFF;
        tick; tick;
        total++; if (digit_en !== 4'b0000) begin bad++; $display("FAIL reset_digit_en got=%b want=0000", digit_en); end
        total++; if (seg_out !== 7'h00) begin bad++; $display("FAIL reset_seg got=%h want=00", seg_out); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_load_ready got=%b want=1", load_ready); end
        clr = 1'b0; enable = 1'b0; load_valid = 1'b0;
        tick;
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset_no_xfer got=%b want=1", load_ready); end
        total++; if (digit_en !== 4'b0000) begin bad++; $display("FAIL idle_dark got=%b want=0000", digit_en); end
    endtask

    task automatic test_scan;
        load_data = 16'h1234; load_valid = 1'b1;
        tick;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL scan_accept got=%b want=0", load_ready); end
        load_valid = 1'b0;
        tick;
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL scan_idle_apply got=%b want=1", load_ready); end
        enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 16; p++) begin
                int d; int c;
                d = p / 4; c = p % 4;
                tick;
                total++; if (digit_en !== exp_en(d, c)) begin bad++; $display("FAIL scan_en f=%0d d=%0d c=%0d got=%b want=%b", f, d, c, digit_en, exp_en(d, c)); end
                total++; if (seg_out !== exp_seg(16'h1234, d, c)) begin bad++; $display("FAIL scan_seg f=%0d d=%0d c=%0d got=%h want=%h", f, d, c, seg_out, exp_seg(16'h1234, d, c)); end
                total++; if (frame_done !== (p == 15)) begin bad++; $display("FAIL scan_fd f=%0d p=%0d got=%b", f, p, frame_done); end
            end
        end
    endtask

    task automatic test_load_mid;
        for (int p = 0; p < 16; p++) begin
            int d; int c;
            d = p / 4; c = p % 4;
            tick;
            if (p == 5) begin
                load_valid = 1'b0;
                total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_low got=%b want=0", load_ready); end
            end
            total++; if (seg_out !== exp_seg(16'h1234, d, c)) begin bad++; $display("FAIL mid_old_seg d=%0d c=%0d got=%h want=%h", d, c, seg_out, exp_seg(16'h1234, d, c)); end
            total++; if (frame_done !== (p == 15)) begin bad++; $display("FAIL mid_fd p=%0d got=%b", p, frame_done); end
            if (p == 15) begin
                total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_at_fd got=%b want=0", load_ready); end
            end
            if (p == 4) begin
                load_data = 16'hABCD; load_valid = 1'b1;
            end
        end
        tick;
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_back got=%b want=1", load_ready); end
        total++; if (digit_en !== 4'b0000) begin bad++; $display("FAIL mid_blank got=%b want=0000", digit_en); end
        tick;
        total++; if (digit_en !== 4'b0001) begin bad++; $display("FAIL mid_new_en got=%b want=0001", digit_en); end
        total++; if (seg_out !== 7'h5E) begin bad++; $display("FAIL mid_new_seg got=%h want=5e", seg_out); end
    endtask

    task automatic test_hold;
        int waited;
        load_data = 16'h5678; load_valid = 1'b1;
        tick;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL hold_accept got=%b want=0", load_ready); end
        load_data = 16'h0F0F;
        waited = 0;
        while (load_ready !== 1'b1 && waited < 40) begin
            tick;
            waited++;
        end
        total++; if (waited !== 14) begin bad++; $display("FAIL hold_wait got=%0d want=14", waited); end
        tick;
        load_valid = 1'b0;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL hold_xfer got=%b want=0", load_ready); end
        total++; if (seg_out !== 7'h7F) begin bad++; $display("FAIL hold_5678_d0 got=%h want=7f", seg_out); end
        for (int p = 2; p < 16; p++) begin
            int d; int c;
            d = p / 4; c = p % 4;
            tick;
            total++; if (seg_out !== exp_seg(16'h5678, d, c)) begin bad++; $display("FAIL hold_seg d=%0d c=%0d got=%h want=%h", d, c, seg_out, exp_seg(16'h5678, d, c)); end
        end
        tick; tick;
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_back got=%b want=1", load_ready); end
        total++; if (seg_out !== 7'h71) begin bad++; $display("FAIL hold_0f0f_d0 got=%h want=71", seg_out); end
        for (int p = 2; p < 16; p++) begin
            int d; int c;
            d = p / 4; c = p % 4;
            tick;
            total++; if (seg_out !== exp_seg(16'h0F0F, d, c)) begin bad++; $display("FAIL hold_new_seg d=%0d c=%0d got=%h want=%h", d, c, seg_out, exp_seg(16'h0F0F, d, c)); end
        end
    endtask

    task automatic test_enable_drop;
        for (int p = 0; p < 10; p++) begin
            tick;
        end
        total++; if (digit_en !== 4'b0100) begin bad++; $display("FAIL drop_pos got=%b want=0100", digit_en); end
        enable = 1'b0;
        tick;
        total++; if (digit_en !== 4'b0000) begin bad++; $display("FAIL drop_dark_en got=%b want=0000", digit_en); end
        total++; if (seg_out !== 7'h00) begin bad++; $display("FAIL drop_dark_seg got=%h want=00", seg_out); end
        for (int k = 0; k < 8; k++) begin
            tick;
            total++; if (frame_done !== 1'b0 || digit_en !== 4'b0000) begin bad++; $display("FAIL drop_idle k=%0d fd=%b en=%b", k, frame_done, digit_en); end
        end
        enable = 1'b1;
        tick;
        total++; if (digit_en !== 4'b0000) begin bad++; $display("FAIL resume_blank got=%b want=0000", digit_en); end
        tick;
        total++; if (digit_en !== 4'b0001) begin bad++; $display("FAIL resume_en got=%b want=0001", digit_en); end
        total++; if (seg_out !== 7'h71) begin bad++; $display("FAIL resume_seg got=%h want=71", seg_out); end
        // Pending load then clr mid-frame
        load_data = 16'h9999; load_valid = 1'b1;
        tick;
        load_valid = 1'b0;
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL clr_pre_pending got=%b want=0", load_ready); end
        clr = 1'b1;
        tick;
        clr = 1'b0;
        total++; if (digit_en !== 4'b0000) begin bad++; $display("FAIL clr_en got=%b want=0000", digit_en); end
        total++; if (seg_out !== 7'h00) begin bad++; $display("FAIL clr_seg got=%h want=00", seg_out); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL clr_fd got=%b want=0", frame_done); end
        total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL clr_ready got=%b want=1", load_ready); end
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 16; p++) begin
                int d; int c;
                d = p / 4; c = p % 4;
                tick;
                total++; if (seg_out !== exp_seg(16'h0000, d, c)) begin bad++; $display("FAIL clr_zero f=%0d d=%0d c=%0d got=%h want=%h", f, d, c, seg_out, exp_seg(16'h0000, d, c)); end
                total++; if (frame_done !== (p == 15)) begin bad++; $display("FAIL clr_fd f=%0d p=%0d got=%b", f, p, frame_done); end
            end
        end
    endtask

    task automatic test_value_0050;
        enable = 1'b0;
        tick;
        load_data = 16'h0050; load_valid = 1'b1;
        tick;
        load_valid = 1'b0;
        tick;
        enable = 1'b1;
        for (int p = 0; p < 16; p++) begin
            int d; int c;
            logic lit;
            logic [3:0] want_en;
            logic [6:0] want_seg;
            d = p / 4; c = p % 4;
            lit = (c != 0);
`ifdef SEG7_LZB_EN
            if (d >= 2) lit = 1'b0;
`endif
            want_en  = lit ? exp_en(d, c) : 4'b0000;
            want_seg = lit ? exp_seg(16'h0050, d, c) : 7'h00;
            tick;
            total++; if (digit_en !== want_en) begin bad++; $display("FAIL lzb_en d=%0d c=%0d got=%b want=%b", d, c, digit_en, want_en); end
            total++; if (seg_out !== want_seg) begin bad++; $display("FAIL lzb_seg d=%0d c=%0d got=%h want=%h", d, c, seg_out, want_seg); end
            total++; if (frame_done !== (p == 15)) begin bad++; $display("FAIL lzb_fd p=%0d got=%b", p, frame_done); end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_load_mid;
        test_hold;
        test_enable_drop;
        test_value_0050;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
